// File: rtl/condiciona_sensores.sv
// Input conditioning for the irrigation controller: per-channel 2-flop sync + debounce.
// Optional sample-enable prescaler enabled by defining DEBOUNCE_PRESCALER_EN.
module condiciona_sensores #(
  parameter int unsigned DEB_CYCLES = 16,
  parameter int unsigned PRESC      = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       H_in,
  input  logic       M_in,
  input  logic       L_in,
  input  logic       Us_in,
  input  logic       Ua_in,
  input  logic       T_in,
  input  logic       Sd_in,
  output logic       H,
  output logic       M,
  output logic       L,
  output logic       Us,
  output logic       Ua,
  output logic       T,
  output logic       Sd,
  output logic [6:0] chg,
  output logic       rdy
);

  localparam int unsigned NCH = 7;
  localparam int unsigned CW  = $clog2(DEB_CYCLES);
  localparam int unsigned RW  = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEB_CYCLES - 1);
  localparam logic [RW-1:0] RDY_LAST = RW'(DEB_CYCLES - 1);

  if (DEB_CYCLES < 2 || DEB_CYCLES > 255) begin : g_deb_range
    $error("condiciona_sensores: DEB_CYCLES out of range 2..255");
  end
  if (PRESC < 2 || PRESC > 65535) begin : g_presc_range
    $error("condiciona_sensores: PRESC out of range 2..65535");
  end

  logic [NCH-1:0]         raw;
  logic [NCH-1:0]         s1;
  logic [NCH-1:0]         s2;
  logic [NCH-1:0]         q;
  logic [NCH-1:0]         q_nxt;
  logic [NCH-1:0]         chg_nxt;
  logic [NCH-1:0][CW-1:0] cnt;
  logic [NCH-1:0][CW-1:0] cnt_nxt;
  logic [RW-1:0]          rcnt;
  logic                   en;

  assign raw = {Sd_in, T_in, Ua_in, Us_in, L_in, M_in, H_in};

`ifdef DEBOUNCE_PRESCALER_EN
  localparam int unsigned PW = $clog2(PRESC);
  localparam logic [PW-1:0] P_LAST = PW'(PRESC - 1);

  logic [PW-1:0] pcnt;

  // Free-running prescaler; en marks the last count of each period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt <= '0;
    end else if (pcnt == P_LAST) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + PW'(1);
    end
  end

  assign en = (pcnt == P_LAST);
`else
  assign en = 1'b1;
`endif

  // Debounce decision: any sample equal to the stable level restarts the window.
  always_comb begin
    q_nxt   = q;
    chg_nxt = '0;
    cnt_nxt = cnt;
    for (int i = 0; i < NCH; i++) begin
      if (s2[i] == q[i]) begin
        cnt_nxt[i] = '0;
      end else if (en) begin
        if (cnt[i] == CNT_MAX) begin
          q_nxt[i]   = s2[i];
          cnt_nxt[i] = '0;
          chg_nxt[i] = 1'b1;
        end else begin
          cnt_nxt[i] = cnt[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1  <= '0;
      s2  <= '0;
      q   <= '0;
      cnt <= '0;
      chg <= '0;
    end else begin
      s1  <= raw;
      s2  <= s1;
      q   <= q_nxt;
      cnt <= cnt_nxt;
      chg <= chg_nxt;
    end
  end

  // Readiness: one full debounce window of enabled samples since reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rcnt <= '0;
      rdy  <= 1'b0;
    end else if (en && !rdy) begin
      rcnt <= rcnt + RW'(1);
      if (rcnt == RDY_LAST) begin
        rdy <= 1'b1;
      end
    end
  end

  assign H  = q[0];
  assign M  = q[1];
  assign L  = q[2];
  assign Us = q[3];
  assign Ua = q[4];
  assign T  = q[5];
  assign Sd = q[6];

endmodule

// File: tb/tb_condiciona_sensores.sv
// Bench for condiciona_sensores: directed table, corner sequences and randomized run
// against a sample-counting reference model.
module tb_condiciona_sensores;

`ifdef DEBOUNCE_PRESCALER_EN
  localparam int DEB   = 3;
  localparam int PRESC = 4;
  localparam int LAT   = 12;
  localparam int RDY_E = 12;
`else
  localparam int DEB   = 16;
  localparam int PRESC = 1000;
  localparam int LAT   = 18;
  localparam int RDY_E = 16;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] raw;
  logic       H, M, L, Us, Ua, T, Sd, rdy;
  logic [6:0] chg;
  logic [6:0] dout;

  always #5 clk = ~clk;

  condiciona_sensores #(.DEB_CYCLES(DEB), .PRESC(PRESC)) dut (
    .clk(clk), .rst(rst),
    .H_in(raw[0]), .M_in(raw[1]), .L_in(raw[2]), .Us_in(raw[3]),
    .Ua_in(raw[4]), .T_in(raw[5]), .Sd_in(raw[6]),
    .H(H), .M(M), .L(L), .Us(Us), .Ua(Ua), .T(T), .Sd(Sd),
    .chg(chg), .rdy(rdy)
  );

  assign dout = {Sd, T, Ua, Us, L, M, H};

  // Reference model: sync delay line plus a count of enabled disagreeing samples.
  logic [6:0] m_s1, m_s2, m_q, m_chg;
  int         m_run [7];
  int         m_ens;
  logic       m_rdy;
  int         m_pc;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  typedef struct {
    logic [6:0] raw;
    int         cycles;
    logic [6:0] out;
    logic [6:0] chg;
  } vec_t;

  vec_t tbl[$];

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_q = '0; m_chg = '0;
    for (int i = 0; i < 7; i++) m_run[i] = 0;
    m_ens = 0; m_rdy = 1'b0; m_pc = 0;
  endtask

  task automatic model_edge(input logic [6:0] r);
    bit en;
`ifdef DEBOUNCE_PRESCALER_EN
    en = (m_pc == PRESC - 1);
    m_pc = (m_pc + 1) % PRESC;
`else
    en = 1'b1;
`endif
    m_chg = '0;
    for (int i = 0; i < 7; i++) begin
      if (m_s2[i] == m_q[i]) m_run[i] = 0;
      else if (en) begin
        m_run[i] = m_run[i] + 1;
        if (m_run[i] == DEB) begin
          m_q[i] = m_s2[i];
          m_run[i] = 0;
          m_chg[i] = 1'b1;
        end
      end
    end
    m_s2 = m_s1;
    m_s1 = r;
    if (en && m_ens < DEB) begin
      m_ens = m_ens + 1;
      if (m_ens == DEB) m_rdy = 1'b1;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    logic [6:0] r;
    r = raw;
    @(posedge clk);
    #1;
    cyc++;
    if (rst) model_reset();
    else model_edge(r);
    chk("model_out", int'(dout), int'(m_q));
    chk("model_chg", int'(chg), int'(m_chg));
    chk("model_rdy", int'(rdy), int'(m_rdy));
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_out", int'(dout), 0);
    chk("rst_chg", int'(chg), 0);
    chk("rst_rdy", int'(rdy), 0);
    repeat (n) step();
    rst = 1'b0;
  endtask

  task automatic add(input logic [6:0] r, input int c, input logic [6:0] o, input logic [6:0] g);
    vec_t v;
    v.raw = r; v.cycles = c; v.out = o; v.chg = g;
    tbl.push_back(v);
  endtask

  initial begin
    logic [6:0] save;
    int mode;

    add(7'h7F, 3,  7'h7F, 7'h00);
    add(7'h00, 17, 7'h7F, 7'h00);
    add(7'h00, 1,  7'h00, 7'h7F);
    add(7'h00, 1,  7'h00, 7'h00);
    add(7'h04, 10, 7'h00, 7'h00);
    add(7'h00, 8,  7'h00, 7'h00);
    add(7'h04, 1,  7'h00, 7'h00);
    add(7'h00, 8,  7'h00, 7'h00);
    add(7'h04, 17, 7'h00, 7'h00);
    add(7'h04, 1,  7'h04, 7'h04);
    add(7'h04, 1,  7'h04, 7'h00);
    add(7'h0C, 15, 7'h04, 7'h00);
    add(7'h04, 1,  7'h04, 7'h00);
    add(7'h0C, 17, 7'h04, 7'h00);
    add(7'h0C, 1,  7'h0C, 7'h08);
    add(7'h4D, 17, 7'h0C, 7'h00);
    add(7'h4D, 1,  7'h4D, 7'h41);
    add(7'h4D, 1,  7'h4D, 7'h00);
    add(7'h4F, 15, 7'h4D, 7'h00);
    add(7'h4D, 5,  7'h4D, 7'h00);

    raw = 7'h7F;
    rst = 1'b0;
    #2;

    // Reset with all inputs high, then full first window.
    do_reset(3);
    for (int k = 1; k <= LAT + 1; k++) begin
      step();
      if (k == RDY_E - 1) chk("rdy_before", int'(rdy), 0);
      if (k == RDY_E)     chk("rdy_rise", int'(rdy), 1);
      if (k == LAT - 1)   chk("first_out_early", int'(dout), 0);
      if (k == LAT) begin
        chk("first_out", int'(dout), 'h7F);
        chk("first_chg", int'(chg), 'h7F);
      end
      if (k == LAT + 1)   chk("first_chg_clear", int'(chg), 0);
    end

    // Directed table: glitches, bounce restart, simultaneous changes, boundary toggle.
    for (int e = 0; e < tbl.size(); e++) begin
      raw = tbl[e].raw;
      for (int c = 0; c < tbl[e].cycles; c++) step();
`ifndef DEBOUNCE_PRESCALER_EN
      chk($sformatf("tbl%0d_out", e), int'(dout), int'(tbl[e].out));
      chk($sformatf("tbl%0d_chg", e), int'(chg), int'(tbl[e].chg));
      chk($sformatf("tbl%0d_rdy", e), int'(rdy), 1);
`endif
    end

    // Reset in the middle of a T window discards the partial count.
    raw = 7'h00;
    do_reset(2);
    raw = 7'h20;
    repeat (10) step();
    rst = 1'b1;
    #1;
    model_reset();
    chk("mid_rst_out", int'(dout), 0);
    repeat (2) step();
    rst = 1'b0;
    for (int k = 1; k <= LAT; k++) begin
      step();
      if (k == LAT - 1) chk("mid_rst_T_early", int'(dout), 0);
      if (k == LAT) begin
        chk("mid_rst_T", int'(dout), 'h20);
        chk("mid_rst_chg", int'(chg), 'h20);
      end
    end

    // Randomized holds, glitches and occasional resets.
    do_reset(2);
    for (int b = 0; b < 400; b++) begin
      mode = int'($urandom_range(0, 19));
      if (mode < 4) begin
        save = raw;
        raw = raw ^ (7'(1) << $urandom_range(0, 6));
        repeat ($urandom_range(1, DEB + 2)) step();
        raw = save;
        repeat ($urandom_range(1, 4)) step();
      end else if (mode == 19) begin
        do_reset(int'($urandom_range(1, 3)));
      end else begin
        raw = 7'($urandom);
        repeat ($urandom_range(1, 2 * LAT)) step();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
